// File: rtl/lc3_datapath_gen2.sv
// Parametrised LC-3 datapath with a memory read/write handshake FSM.
// Define DP_BUS_CHECK_EN to flag multi-gate bus conflicts on bus_err.
module lc3_datapath_gen2 #(
    parameter int          WIDTH  = 16,
    parameter int          NREGS  = 8,
    parameter logic [15:0] PC_RST = 16'h0000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_REG,
    input  logic             LD_PC,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic [1:0]       PCMUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic             MARMUX,
    input  logic             SR1MUX,
    input  logic             DRMUX,
    input  logic             SR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_busy,
    output logic             mem_done,
    output logic             BEN,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
    output logic             bus_err,
    output logic [1:0]       mem_state_dbg
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // DONE separates the MDR capture edge from the mem_done pulse edge.
    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_DONE} mem_state_e;
    mem_state_e state_q, state_d;

    logic [WIDTH-1:0] mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d, pc_q, pc_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [2:0]       nzp_q, nzp_d;
    logic             ben_q, ben_d, done_q, done_d;
    logic [2:0]       sr1_idx, dr_idx, sr2_idx;
    logic [WIDTH-1:0] bus, alu_out, alu_b, sr1_val, sr2_val;
    logic [WIDTH-1:0] addr1, addr2, adder_out, marmux_out;
    logic             busy;

`ifdef DP_BUS_CHECK_EN
    logic multi_gate;
    logic bus_err_q, bus_err_d;
    assign multi_gate = ($countones({GateMDR, GateALU, GatePC, GateMARMUX}) > 1);
    assign bus_err_d  = bus_err_q | multi_gate;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) bus_err_q <= 1'b0;
        else        bus_err_q <= bus_err_d;
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_comb begin
        sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
        dr_idx  = DRMUX ? 3'b111 : ir_q[11:9];
        sr2_idx = ir_q[2:0];
    end

    assign sr1_val = regs_q[sr1_idx[AW-1:0]];
    assign sr2_val = regs_q[sr2_idx[AW-1:0]];

    always_comb begin
        alu_b   = SR2MUX ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : sr2_val;
        alu_out = sr1_val;
        unique case (ALUK)
            2'd0:    alu_out = sr1_val + alu_b;
            2'd1:    alu_out = sr1_val & alu_b;
            2'd2:    alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    always_comb begin
        addr1 = ADDR1MUX ? sr1_val : pc_q;
        addr2 = '0;
        unique case (ADDR2MUX)
            2'd0:    addr2 = '0;
            2'd1:    addr2 = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
            2'd2:    addr2 = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
            default: addr2 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
        endcase
        adder_out  = addr1 + addr2;
        marmux_out = MARMUX ? adder_out : {{(WIDTH-8){1'b0}}, ir_q[7:0]};
    end

    always_comb begin
        bus = '0;
        if (GateMDR)         bus = mdr_q;
        else if (GateALU)    bus = alu_out;
        else if (GatePC)     bus = pc_q;
        else if (GateMARMUX) bus = marmux_out;
`ifdef DP_BUS_CHECK_EN
        if (multi_gate) begin
`ifdef SYNTHESIS
            bus = '0;
`else
            bus = 'x;
`endif
        end
`endif
    end

    // Memory handshake: only IDLE accepts starts; ack is sampled only in WAIT states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_rd)      state_d = S_RD_WAIT;
                else if (mem_wr) state_d = S_WR_WAIT;
            end
            S_RD_WAIT: if (mem_ack) state_d = S_DONE;
            S_WR_WAIT: if (mem_ack) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        mar_d  = mar_q;
        mdr_d  = mdr_q;
        ir_d   = LD_IR ? bus : ir_q;
        pc_d   = pc_q;
        nzp_d  = nzp_q;
        ben_d  = LD_BEN ? |(ir_q[11:9] & nzp_q) : ben_q;
        done_d = (state_q == S_DONE);
        if (LD_MAR && !busy) mar_d = bus;
        if (state_q == S_RD_WAIT && mem_ack) mdr_d = mem_rdata;
        else if (LD_MDR && !busy)            mdr_d = bus;
        if (LD_PC) begin
            unique case (PCMUX)
                2'd0:    pc_d = pc_q + WIDTH'(1);
                2'd1:    pc_d = bus;
                2'd2:    pc_d = adder_out;
                default: pc_d = pc_q;
            endcase
        end
        if (LD_CC) begin
            if (bus[WIDTH-1])  nzp_d = 3'b100;
            else if (bus == 0) nzp_d = 3'b010;
            else               nzp_d = 3'b001;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            pc_q    <= WIDTH'(PC_RST);
            nzp_q   <= 3'b010;
            ben_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (LD_REG) begin
            regs_q[dr_idx[AW-1:0]] <= bus;
        end
    end

    assign mem_req       = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    assign mem_we        = (state_q == S_WR_WAIT);
    assign mem_busy      = busy;
    assign mem_done      = done_q;
    assign BEN           = ben_q;
    assign MAR           = mar_q;
    assign MDR           = mdr_q;
    assign IR            = ir_q;
    assign PC            = pc_q;
    assign mem_state_dbg = state_q;
endmodule
